// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, special opcodes and fetch FSM states.
package cpu_pkg;

   localparam int unsigned OP_MSB  = 23;
   localparam int unsigned OP_LSB  = 20;
   localparam int unsigned F_MSB   = 19;
   localparam int unsigned F_LSB   = 16;
   localparam int unsigned RD_MSB  = 15;
   localparam int unsigned RD_LSB  = 12;
   localparam int unsigned RA_MSB  = 11;
   localparam int unsigned RA_LSB  = 8;
   localparam int unsigned RB_MSB  = 7;
   localparam int unsigned RB_LSB  = 4;
   localparam int unsigned IMM_MSB = 11;
   localparam int unsigned IMM_LSB = 0;

   localparam logic [3:0] OPC_HALT = 4'b1101;
   localparam logic [3:0] OPC_JUMP = 4'b1001;

   typedef enum logic [1:0] {
      S_WARM,
      S_RUN,
      S_FLUSH,
      S_HALT
   } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load has priority over hold; otherwise increments, wrapping modulo 2^ADDR_W.
module pc_counter #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              hold,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= ADDR_W'(RESET_PC);
      end else if (load) begin
         r_pc <= target;
      end else if (!hold) begin
         r_pc <= r_pc + ADDR_W'(1);
      end
   end

   assign pc = r_pc;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage with IF/ID register: PC, synchronous-ROM fetch, stall, branch redirect, flush.
// Optional HALT opcode support is built when IFETCH_HALT_EN is defined.
module instr_fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              stall,
   input  logic              salto,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [3:0]        id_opcode,
   output logic [3:0]        id_f,
   output logic [3:0]        id_rd,
   output logic [3:0]        id_ra,
   output logic [3:0]        id_rb,
   output logic [11:0]       id_imm,
   output logic              halted
);

   fetch_state_e      r_state;
   logic [ADDR_W-1:0] r_fpc;
   logic [ADDR_W-1:0] r_id_pc;
   logic [DATA_W-1:0] r_id_instr;
   logic              r_id_valid;
   logic [ADDR_W-1:0] w_pc;
   logic              w_take;
   logic              w_freeze;

`ifdef IFETCH_HALT_EN
   logic r_halted;
   assign w_freeze = (r_state == S_HALT);
   assign halted   = r_halted;
`else
   assign w_freeze = 1'b0;
   assign halted   = 1'b0;
`endif

   // Only a real instruction in IF/ID during normal fetch can redirect.
   assign w_take = salto & ~stall & r_id_valid & (r_state == S_RUN);

   pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (w_take),
      .hold   (stall | w_freeze),
      .target (branch_target),
      .pc     (w_pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_WARM;
         r_fpc      <= ADDR_W'(RESET_PC);
         r_id_valid <= 1'b0;
         r_id_pc    <= '0;
         r_id_instr <= '0;
`ifdef IFETCH_HALT_EN
         r_halted   <= 1'b0;
`endif
      end else if (!stall) begin
         case (r_state)
            S_WARM: begin
               r_fpc   <= w_pc;
               r_state <= S_RUN;
            end
            S_RUN: begin
               r_fpc <= w_pc;
               if (w_take) begin
                  r_id_valid <= 1'b0;
                  r_id_pc    <= '0;
                  r_id_instr <= '0;
                  r_state    <= S_FLUSH;
               end else begin
                  r_id_valid <= 1'b1;
                  r_id_pc    <= r_fpc;
                  r_id_instr <= imem_data;
`ifdef IFETCH_HALT_EN
                  if (imem_data[OP_MSB:OP_LSB] == OPC_HALT) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end
`endif
               end
            end
            S_FLUSH: begin
               r_id_valid <= 1'b0;
               r_id_pc    <= '0;
               r_id_instr <= '0;
               r_fpc      <= w_pc;
               r_state    <= S_RUN;
            end
`ifdef IFETCH_HALT_EN
            S_HALT: begin
               r_id_valid <= 1'b0;
               r_id_pc    <= '0;
               r_id_instr <= '0;
            end
`endif
            default: r_state <= S_WARM;
         endcase
      end
   end

   assign imem_addr = w_pc;
   assign imem_rd   = ~stall & ~w_freeze;
   assign id_valid  = r_id_valid;
   assign id_pc     = r_id_pc;
   assign id_opcode = r_id_instr[OP_MSB:OP_LSB];
   assign id_f      = r_id_instr[F_MSB:F_LSB];
   assign id_rd     = r_id_instr[RD_MSB:RD_LSB];
   assign id_ra     = r_id_instr[RA_MSB:RA_LSB];
   assign id_rb     = r_id_instr[RB_MSB:RB_LSB];
   assign id_imm    = r_id_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: per-cycle IF/ID expectations queued and checked against a ROM model.
module tb_instr_fetch_stage;

   localparam int unsigned DATA_W = 24;
   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rd;
   logic [DATA_W-1:0] imem_data;
   logic              stall = 1'b0;
   logic              salto = 1'b0;
   logic [ADDR_W-1:0] branch_target = '0;
   logic              id_valid;
   logic [ADDR_W-1:0] id_pc;
   logic [3:0]        id_opcode;
   logic [3:0]        id_f;
   logic [3:0]        id_rd;
   logic [3:0]        id_ra;
   logic [3:0]        id_rb;
   logic [11:0]       id_imm;
   logic              halted;

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] pc;
   } exp_t;

   localparam exp_t BUB = '0;

   exp_t              q[$];
   logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
   int unsigned       total = 0;
   int unsigned       bad = 0;
   logic [42:0]       obs;

   assign obs = {id_valid, id_pc, id_opcode, id_f, id_rd, id_ra, id_rb, id_imm};

   instr_fetch_stage #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .RESET_PC (0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_rd       (imem_rd),
      .imem_data     (imem_data),
      .stall         (stall),
      .salto         (salto),
      .branch_target (branch_target),
      .id_valid      (id_valid),
      .id_pc         (id_pc),
      .id_opcode     (id_opcode),
      .id_f          (id_f),
      .id_rd         (id_rd),
      .id_ra         (id_ra),
      .id_rb         (id_rb),
      .id_imm        (id_imm),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: output only changes on an enabled read.
   always_ff @(posedge clk) begin
      if (imem_rd) imem_data <= rom[imem_addr];
   end

   function automatic exp_t ins(input logic [ADDR_W-1:0] pc);
      exp_t e;
      e.v  = 1'b1;
      e.pc = pc;
      return e;
   endfunction

   function automatic logic [42:0] model(input exp_t e);
      logic [DATA_W-1:0] w;
      if (!e.v) return '0;
      w = rom[e.pc];
      return {1'b1, e.pc, w[23:20], w[19:16], w[15:12], w[11:8], w[7:4], w[11:0]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stall = 1'b0;
      salto = 1'b0;
      branch_target = '0;
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #12;
      total++;
      if (obs !== 43'd0) begin bad++; $display("FAIL reset_id: got %h expected 0", obs); end
      total++;
      if (imem_addr !== 10'd0) begin bad++; $display("FAIL reset_addr: got %h expected 000", imem_addr); end
      total++;
      if (imem_rd !== 1'b1) begin bad++; $display("FAIL reset_rd: got %b expected 1", imem_rd); end
      total++;
      if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b expected 0", halted); end
   endtask

   task automatic test_sequential();
      exp_t e;
      do_reset();
      for (int k = -1; k < 20; k++) begin
         q.push_back((k < 0) ? BUB : ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL seq_ifid[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      exp_t e;
      do_reset();
      for (int k = -1; k <= 5; k++) begin
         q.push_back((k < 0) ? BUB : ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL stall_pre[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         q.push_back(ins(10'd5));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL stall_hold[%0d]: got %h expected %h", k, obs, model(e)); end
         total++;
         if (imem_rd !== 1'b0) begin bad++; $display("FAIL stall_rd[%0d]: got %b expected 0", k, imem_rd); end
         @(negedge clk);
      end
      stall = 1'b0;
      for (int k = 6; k <= 8; k++) begin
         q.push_back(ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL stall_resume[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      exp_t e;
      do_reset();
      for (int k = -1; k <= 16; k++) begin
         q.push_back((k < 0) ? BUB : ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL br_pre[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
      for (int k = 0; k < 5; k++) begin
         salto = (k == 0);
         branch_target = 10'h040;
         q.push_back((k < 2) ? BUB : ins(ADDR_W'(10'h040 + k - 2)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL br_redirect[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
      salto = 1'b0;
   endtask

   task automatic test_salto_stall();
      exp_t e;
      do_reset();
      for (int k = -1; k <= 16; k++) begin
         q.push_back((k < 0) ? BUB : ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL sst_pre[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
      for (int k = 0; k < 6; k++) begin
         stall = (k < 2);
         salto = (k < 3);
         branch_target = 10'h040;
         if (k < 2)      q.push_back(ins(10'h010));
         else if (k < 4) q.push_back(BUB);
         else            q.push_back(ins(ADDR_W'(10'h040 + k - 4)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL sst_branch[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
      stall = 1'b0;
      salto = 1'b0;
   endtask

   task automatic test_wrap();
      exp_t e;
      do_reset();
      for (int k = -1; k <= 2; k++) begin
         q.push_back((k < 0) ? BUB : ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL wrap_pre[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
      for (int k = 0; k < 6; k++) begin
         salto = (k == 0);
         branch_target = 10'h3FE;
         q.push_back((k < 2) ? BUB : ins(ADDR_W'(10'h3FE + k - 2)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL wrap[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
      salto = 1'b0;
   endtask

   task automatic test_halt();
      exp_t        e;
      logic [23:0] saved;
      saved = rom[3];
      rom[3] = 24'hD00000;
      do_reset();
`ifdef IFETCH_HALT_EN
      for (int k = -1; k <= 3; k++) begin
         q.push_back((k < 0) ? BUB : ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL halt_pre[%0d]: got %h expected %h", k, obs, model(e)); end
         total++;
         if (halted !== (k == 3)) begin bad++; $display("FAIL halt_flag[%0d]: got %b expected %b", k, halted, (k == 3)); end
         @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
         salto = (k == 1);
         branch_target = 10'h040;
         q.push_back(BUB);
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL halt_bubble[%0d]: got %h expected %h", k, obs, model(e)); end
         total++;
         if ({halted, imem_rd, imem_addr} !== {1'b1, 1'b0, 10'd5}) begin
            bad++; $display("FAIL halt_frozen[%0d]: got %b/%b/%h expected 1/0/005", k, halted, imem_rd, imem_addr);
         end
         @(negedge clk);
      end
      salto = 1'b0;
`else
      for (int k = -1; k <= 6; k++) begin
         q.push_back((k < 0) ? BUB : ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL d_pass[%0d]: got %h expected %h", k, obs, model(e)); end
         total++;
         if (halted !== 1'b0) begin bad++; $display("FAIL d_halted[%0d]: got %b expected 0", k, halted); end
         @(negedge clk);
      end
`endif
      // Asynchronous reset asserted between clock edges.
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({obs, halted, imem_addr} !== 54'd0) begin
         bad++; $display("FAIL async_reset: got %h/%b/%h expected 0/0/000", obs, halted, imem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      for (int k = -1; k <= 2; k++) begin
         q.push_back((k < 0) ? BUB : ins(ADDR_W'(k)));
         @(posedge clk); #1;
         e = q.pop_front();
         total++;
         if (obs !== model(e)) begin bad++; $display("FAIL restart[%0d]: got %h expected %h", k, obs, model(e)); end
         @(negedge clk);
      end
      rom[3] = saved;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         rom[i] = {4'(i % 13), 20'(i * 977)};
      end
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_salto_stall();
      test_wrap();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage with IF/ID pipeline register that feeds the control unit. It holds the program counter, addresses a synchronous instruction ROM, and splits each fetched word into the opcode and function fields the control unit decodes, plus register and immediate fields. It supports downstream stall, taken-branch redirect (driven by the control unit's SALTO), and the resulting pipeline flush.

## Interface
- `DATA_W`, 24: instruction width.
- `ADDR_W`, 10: instruction address width; the PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  ADDR_W  ROM read address.
- `imem_rd`  out  1  ROM read enable.
- `imem_data`  in  DATA_W  ROM read data; valid one cycle after the address.
- `stall`  in  1  decode cannot accept a new instruction; hold everything.
- `salto`  in  1  taken branch for the instruction currently in IF/ID.
- `branch_target`  in  ADDR_W  branch destination, sampled with `salto`.
- `id_valid`  out  1  IF/ID holds a real instruction; 0 means a bubble.
- `id_pc`  out  ADDR_W  address of the IF/ID instruction.
- `id_opcode`  out  4  bits [23:20]; goes to control unit OpCode.
- `id_f`  out  4  bits [19:16]; goes to control unit F.
- `id_rd`, `id_ra`, `id_rb`  out  4 each  bits [15:12], [11:8], [7:4].
- `id_imm`  out  12  bits [11:0], raw; extension is done downstream.
- `halted`  out  1  fetch stopped on HALT (see Configuration).

## Operation
- Registers:
  - `pc_q` is the address presented on `imem_addr`.
  - `fpc_q` is the address whose data is on `imem_data`.
  - The IF/ID register holds all `id_*` outputs.
- FSM states:
  - WARM: first cycle after reset; ROM data is not yet valid. Always goes to RUN.
  - RUN: normal fetch.
  - FLUSH: the ROM output belongs to a wrong-path address.
  - HALT: fetch stopped.
- RUN with `stall`=0:
  - IF/ID captures `imem_data`, `fpc_q` and `id_valid`=1.
  - `fpc_q`<=`pc_q`; `pc_q`<=`pc_q`+1 (wraps from 2^ADDR_W-1 to 0).
- Any state with `stall`=1:
  - `pc_q`, `fpc_q`, IF/ID and the state all hold.
  - `imem_rd`=0.
  - The ROM keeps its last output, so no data is lost.
- Branch condition: `salto`=1, `stall`=0 and `id_valid`=1. When it holds:
  - `pc_q`<=`branch_target`.
  - IF/ID loads a bubble: `id_valid`=0, all fields 0.
  - State goes to FLUSH.
- `salto` is ignored while `stall`=1 or `id_valid`=0.
- FLUSH with `stall`=0:
  - Load a bubble into IF/ID.
  - `fpc_q`<=`pc_q`; `pc_q`<=`pc_q`+1.
  - Go to RUN.
- A branch arriving in FLUSH cannot occur, because IF/ID holds a bubble.
- Bubble rule: the control unit still decodes opcode 0000 during a bubble, so downstream write enables must be gated with `id_valid`.

## Timing
- Reset values:
  - `imem_addr`=RESET_PC, `imem_rd`=1.
  - `id_valid`=0, every `id_*` field=0.
  - `halted`=0, state WARM.
- Fetch-to-IF/ID latency is 2 cycles: the first valid instruction (RESET_PC) appears in IF/ID on the 2nd rising edge after `rst_n` deasserts.
- Taken-branch penalty is 2 bubbles. Branch at b in IF/ID on cycle T: the b+1 and b+2 slots are squashed, and the target appears in IF/ID after edge T+3.
- Sustained throughput is one instruction per cycle with no stall or branch.
- Reset mid-operation clears everything asynchronously; fetch restarts from RESET_PC with WARM.

## Configuration
- `IFETCH_HALT_EN` defined:
  - Opcode 4'b1101 is HALT.
  - When HALT is captured into IF/ID (`id_valid`=1), the state goes to HALT. `halted`=1, `imem_rd`=0, `pc_q` freezes.
  - From the next edge on, IF/ID loads bubbles.
  - Only `rst_n` leaves HALT; `salto` is ignored there.
- Macro undefined:
  - 1101 passes through as an ordinary instruction.
  - `halted` is tied to 0 and the HALT state is not built.

## Structure
- Shared package `cpu_pkg` holds:
  - Field bit positions (OP_MSB/LSB, F, RD, RA, RB, IMM).
  - `OPC_HALT`=4'b1101 and `OPC_JUMP`=4'b1001.
  - The fetch state enum.
- One sub-module, `pc_counter`: loadable, holdable, wrapping PC register (`load`, `hold`, `target`).

## Test plan
- Reset, no stall, ROM[i]=i: `id_pc` = 0,1,2,… starting on the 2nd edge after reset; `id_opcode`=ROM[k][23:20] each cycle.
- `stall` high 3 cycles with 5 in IF/ID: `id_pc` stays 5, `imem_rd`=0; resumes with 6 with no gap or duplicate.
- `salto`=1, `branch_target`=0x040 with b=0x010 in IF/ID: exactly 2 bubbles (`id_valid`=0), then `id_pc`=0x040, 0x041.
- `salto` and `stall` both high for 2 cycles, then `stall` drops: branch is taken only on the unstalled cycle, with the same 2-bubble penalty.
- PC at 0x3FF (ADDR_W=10): next `id_pc` is 0x000.
- With `IFETCH_HALT_EN`, ROM[3]=0xD00000: `halted`=1 after `id_pc`=3, then only bubbles. Asserting `rst_n`=0 mid-run clears `halted` and restarts at 0.
